reg32_avalon_master: RTL

//  Avalon-MM host that drives the 24-bit reg32 agent (write, clear, read, verify) from a simple command port.

---
 rtl/reg32_avalon_pkg.sv | 33 +++
 rtl/reg32_avalon_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg32_avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg32_avalon_pkg
// Brief    : Shared op encodings, FSM states and byte-swap helper for the
//            reg32 Avalon-MM host.
// Revision : 1.0
// ============================================================================
package reg32_avalon_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_VERIFY = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam int CLEAR_BIT = 24;

  // The agent returns register bytes in reverse order; this restores d[23:0].
  function automatic logic [23:0] swap24(input logic [23:0] d);
    return {d[7:0], d[15:8], d[23:16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg32_avalon_master.sv
`default_nettype none
// ============================================================================
// Module   : reg32_avalon_master
// Brief    : Avalon-MM host driving the 24-bit reg32 agent (write, clear,
//            read, verify) from a single-outstanding command port.
// Revision : 1.0
// ============================================================================
module reg32_avalon_master
  import reg32_avalon_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [23:0]       cmd_data,
  input  logic [2:0]        cmd_be,
  output logic              resp_valid,
  output logic [23:0]       resp_data,
  output logic              resp_match,
  output logic              resp_error,
  output logic [ADDR_W-1:0] av_address,
  output logic [3:0]        av_byteenable,
  output logic [31:0]       av_writedata,
  output logic              av_write,
  output logic              av_read,
  input  logic [31:0]       av_readdata,
  input  logic              av_waitrequest,
  input  logic              av_readdatavalid
);

  localparam logic [7:0]  c_TIMEOUT     = 8'(TIMEOUT);
  localparam logic [31:0] c_CLEAR_WDATA = 32'h1 << CLEAR_BIT;
  localparam logic [3:0]  c_CLEAR_BE    = 4'b1000;
  localparam logic [3:0]  c_READ_BE     = 4'b0111;

  state_e      r_state;
  state_e      w_next;
  op_e         r_op;
  logic [23:0] r_data;
  logic [2:0]  r_be;
  logic [31:0] r_wdata;
  logic [3:0]  r_wbe;
  logic [7:0]  r_cnt;
  logic [23:0] r_rd;
  logic        r_rd_got;
  logic [23:0] r_resp_data;
  logic        r_resp_match;
  logic        r_resp_error;

  logic        w_accept;
  logic        w_timeout;
  logic        w_cnt_hit;
  logic        w_busy_state;
  logic [23:0] w_rd_final;
  logic [23:0] w_mask;
  logic        w_unused;

  assign w_unused     = &{1'b0, av_readdata[31:24]};
  assign av_address   = ADDR_W'(BASE_ADDR);
  assign cmd_ready    = (r_state == ST_IDLE);
  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  assign w_cnt_hit    = (r_cnt >= c_TIMEOUT);
  assign w_busy_state = (r_state == ST_WR) || (r_state == ST_RD_REQ) ||
                        (r_state == ST_RD_WAIT);
  assign resp_valid   = (r_state == ST_RESP);
  assign resp_data    = r_resp_data;
  assign resp_match   = r_resp_match;
  assign resp_error   = r_resp_error;

  // Read data may have been captured early, in the same cycle the read was accepted.
  assign w_rd_final = r_rd_got ? r_rd : swap24(av_readdata[23:0]);
  assign w_mask     = {{8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_timeout     = 1'b0;
    av_write      = 1'b0;
    av_read       = 1'b0;
    av_byteenable = 4'b0000;
    av_writedata  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (cmd_op == OP_READ) ? ST_RD_REQ : ST_WR;
        end
      end
      ST_WR: begin
        av_write      = 1'b1;
        av_byteenable = r_wbe;
        av_writedata  = r_wdata;
        if (!av_waitrequest) begin
          w_next = (r_op == OP_VERIFY) ? ST_RD_REQ : ST_RESP;
        end else if (w_cnt_hit) begin
          w_next    = ST_RESP;
          w_timeout = 1'b1;
        end
      end
      ST_RD_REQ: begin
        av_read       = 1'b1;
        av_byteenable = c_READ_BE;
        if (!av_waitrequest) begin
          w_next = ST_RD_WAIT;
        end else if (w_cnt_hit) begin
          w_next    = ST_RESP;
          w_timeout = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (r_rd_got || av_readdatavalid) begin
          w_next = ST_RESP;
        end else if (w_cnt_hit) begin
          w_next    = ST_RESP;
          w_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= OP_WRITE;
      r_data       <= 24'h0;
      r_be         <= 3'b000;
      r_wdata      <= 32'h0;
      r_wbe        <= 4'b0000;
      r_cnt        <= 8'h00;
      r_rd         <= 24'h0;
      r_rd_got     <= 1'b0;
      r_resp_data  <= 24'h0;
      r_resp_match <= 1'b0;
      r_resp_error <= 1'b0;
    end else begin
      // Cleared on every state change, saturating while stalled.
      if (w_next != r_state) begin
        r_cnt <= 8'h00;
      end else if (w_busy_state && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_accept) begin
        r_op         <= op_e'(cmd_op);
        r_data       <= cmd_data;
        r_be         <= cmd_be;
        r_rd_got     <= 1'b0;
        r_resp_data  <= 24'h0;
        r_resp_match <= 1'b0;
        r_resp_error <= 1'b0;
        if (cmd_op == OP_CLEAR) begin
          r_wdata <= c_CLEAR_WDATA;
          r_wbe   <= c_CLEAR_BE;
        end else begin
          r_wdata <= {8'h00, cmd_data};
          r_wbe   <= {1'b0, cmd_be};
        end
      end

      if ((r_state == ST_RD_REQ) && !av_waitrequest && av_readdatavalid) begin
        r_rd     <= swap24(av_readdata[23:0]);
        r_rd_got <= 1'b1;
      end

      if ((r_state != ST_RESP) && (w_next == ST_RESP)) begin
        if (w_timeout) begin
          r_resp_data  <= 24'h0;
          r_resp_match <= 1'b0;
          r_resp_error <= 1'b1;
        end else begin
          r_resp_error <= 1'b0;
          case (r_op)
            OP_READ: begin
              r_resp_data  <= w_rd_final;
              r_resp_match <= 1'b0;
            end
            OP_VERIFY: begin
              r_resp_data  <= w_rd_final;
              r_resp_match <= ~|((w_rd_final ^ r_data) & w_mask);
            end
            default: begin
              r_resp_data  <= 24'h0;
              r_resp_match <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
